// File: rtl/event_encoder16x4_seq.sv
// event_encoder16x4_seq
//   Sequential 16-to-4 event encoder. Request lines are OR-ed into a sticky
//   pending register every cycle. One pending event at a time is presented as
//   a 4-bit index on a valid/ready interface.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   clr        synchronous clear of all pending/presented state
//   in         request lines, level high = request, sampled every edge
//   out_ready  consumer accepts out_idx this cycle
//   out_valid  out_idx holds a valid event
//   out_idx    index of the presented event
//   pending    not-yet-accepted events, including the presented one
//   merged     1-cycle pulse: a request hit a bit that was already pending
module event_encoder16x4_seq #(
   parameter int unsigned N_IN        = 16,
   parameter int unsigned IDX_W       = 4,
   parameter bit          ROUND_ROBIN = 1'b0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic [N_IN-1:0]  in,
   input  logic             out_ready,
   output logic             out_valid,
   output logic [IDX_W-1:0] out_idx,
   output logic [N_IN-1:0]  pending,
   output logic             merged
);

   typedef enum logic {EMPTY, PRESENT} state_t;

   state_t             state_q, state_d;
   logic [N_IN-1:0]    pending_q;
   logic [N_IN-1:0]    pop_mask;
   logic [N_IN-1:0]    cand;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [IDX_W-1:0]   rr_ptr_q;
   logic [IDX_W-1:0]   scan_base;
   logic [IDX_W-1:0]   sel_idx;
   logic               sel_found;
   logic               acc;
   logic               merged_q;

   // Candidate set: pending bits minus the one being accepted, plus new
   // requests. A request on the accepted index keeps that bit (set beats pop).
   always_comb begin
      acc      = (state_q == PRESENT) && out_ready;
      pop_mask = '0;
      if (acc) pop_mask[idx_q] = 1'b1;
      cand = (pending_q & ~pop_mask) | in;
   end

   // Round-robin scan starts just after the most recently accepted index;
   // in an accept cycle that is the index leaving now, not the stored pointer.
   // The IDX_W-wide addition wraps 15 -> 0 on its own.
   always_comb begin
      if (ROUND_ROBIN) scan_base = (acc ? idx_q : rr_ptr_q) + 1'b1;
      else             scan_base = '0;
   end

   always_comb begin
      logic [IDX_W-1:0] pos;
      pos       = '0;
      sel_idx   = '0;
      sel_found = 1'b0;
      for (int unsigned k = 0; k < N_IN; k++) begin
         pos = scan_base + IDX_W'(k);
         if (!sel_found && cand[pos]) begin
            sel_idx   = pos;
            sel_found = 1'b1;
         end
      end
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)   state_q <= EMPTY;
      else if (clr) state_q <= EMPTY;
      else          state_q <= state_d;
   end

   // Next-state: reload the presented index when empty or on accept;
   // a stalled presentation is held.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      if (state_q == EMPTY || acc) begin
         if (sel_found) begin
            state_d = PRESENT;
            idx_d   = sel_idx;
         end else begin
            state_d = EMPTY;
         end
      end
   end

   // Datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending_q <= '0;
         idx_q     <= '0;
         rr_ptr_q  <= IDX_W'(N_IN - 1);
         merged_q  <= 1'b0;
      end else if (clr) begin
         pending_q <= '0;
         idx_q     <= '0;
         rr_ptr_q  <= IDX_W'(N_IN - 1);
         merged_q  <= 1'b0;
      end else begin
         pending_q <= cand;
         idx_q     <= idx_d;
         if (acc) rr_ptr_q <= idx_q;
         merged_q  <= |(in & pending_q & ~pop_mask);
      end
   end

   // Outputs
   always_comb begin
      out_valid = (state_q == PRESENT);
      out_idx   = idx_q;
      pending   = pending_q;
      merged    = merged_q;
   end

endmodule

// File: tb/tb_event_encoder16x4_seq.sv
// Testbench for event_encoder16x4_seq: a fixed-priority and a round-robin
// instance share one stimulus stream and are each compared against a
// per-event reference model after every clock.
module tb_event_encoder16x4_seq;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        clr;
   logic [15:0] in;
   logic        out_ready;

   logic        fp_valid, rr_valid;
   logic [3:0]  fp_idx,   rr_idx;
   logic [15:0] fp_pend,  rr_pend;
   logic        fp_mrg,   rr_mrg;

   int passed = 0;
   int total  = 0;

   // Reference state, index 0 = fixed priority, 1 = round robin
   logic [15:0] m_pend [2];
   bit          m_v    [2];
   int          m_idx  [2];
   int          m_ptr  [2];
   bit          m_mrg  [2];

   always #5 clk = ~clk;

   event_encoder16x4_seq #(.N_IN(16), .IDX_W(4), .ROUND_ROBIN(1'b0)) u_fp (
      .clk(clk), .rst_n(rst_n), .clr(clr), .in(in), .out_ready(out_ready),
      .out_valid(fp_valid), .out_idx(fp_idx), .pending(fp_pend), .merged(fp_mrg)
   );

   event_encoder16x4_seq #(.N_IN(16), .IDX_W(4), .ROUND_ROBIN(1'b1)) u_rr (
      .clk(clk), .rst_n(rst_n), .clr(clr), .in(in), .out_ready(out_ready),
      .out_valid(rr_valid), .out_idx(rr_idx), .pending(rr_pend), .merged(rr_mrg)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   function automatic void mreset();
      for (int r = 0; r < 2; r++) begin
         m_pend[r] = '0; m_v[r] = 0; m_idx[r] = 0; m_ptr[r] = 15; m_mrg[r] = 0;
      end
   endfunction

   // One clock edge of the event encoder, described per event rather than
   // per register: which events survive, which one is shown next.
   function automatic void mstep(input int r, input logic [15:0] vin, input bit rdy, input bit c);
      logic [15:0] np;
      bit acc, keep;
      int popi, base, found, j;
      if (c) begin
         m_pend[r] = '0; m_v[r] = 0; m_idx[r] = 0; m_ptr[r] = 15; m_mrg[r] = 0;
         return;
      end
      acc  = m_v[r] && rdy;
      popi = acc ? m_idx[r] : -1;
      m_mrg[r] = 0;
      np = '0;
      for (int i = 0; i < 16; i++) begin
         keep = m_pend[r][i] && (i != popi);
         if (vin[i] && keep) m_mrg[r] = 1;
         np[i] = vin[i] || keep;
      end
      if (!m_v[r] || acc) begin
         base  = (r == 1) ? ((acc ? m_idx[r] : m_ptr[r]) + 1) : 0;
         found = -1;
         for (int k = 0; k < 16; k++) begin
            j = (base + k) % 16;
            if (found < 0 && np[j]) found = j;
         end
         if (acc) m_ptr[r] = m_idx[r];
         m_v[r] = (found >= 0);
         if (found >= 0) m_idx[r] = found;
      end
      m_pend[r] = np;
   endfunction

   task automatic check_all();
      check("fp_valid",  {31'd0, fp_valid}, {31'd0, m_v[0]});
      check("fp_pend",   {16'd0, fp_pend},  {16'd0, m_pend[0]});
      check("fp_merged", {31'd0, fp_mrg},   {31'd0, m_mrg[0]});
      if (m_v[0]) check("fp_idx", {28'd0, fp_idx}, m_idx[0]);
      check("rr_valid",  {31'd0, rr_valid}, {31'd0, m_v[1]});
      check("rr_pend",   {16'd0, rr_pend},  {16'd0, m_pend[1]});
      check("rr_merged", {31'd0, rr_mrg},   {31'd0, m_mrg[1]});
      if (m_v[1]) check("rr_idx", {28'd0, rr_idx}, m_idx[1]);
   endtask

   // Drive one cycle of inputs (just after an edge), clock it, check #1 later.
   task automatic step(input logic [15:0] vin, input bit rdy, input bit c);
      in = vin; out_ready = rdy; clr = c;
      mstep(0, vin, rdy, c);
      mstep(1, vin, rdy, c);
      @(posedge clk);
      #1;
      check_all();
   endtask

   initial begin
      rst_n = 1'b0; clr = 1'b0; in = '0; out_ready = 1'b0;
      mreset();
      @(posedge clk); @(posedge clk); #1;
      check("rst_valid", {31'd0, fp_valid}, 32'd0);
      check("rst_idx",   {28'd0, fp_idx},   32'd0);
      check("rst_pend",  {16'd0, rr_pend},  32'd0);
      check("rst_merged",{31'd0, rr_mrg},   32'd0);
      rst_n = 1'b1;

      // Single event, one-cycle latency
      step(16'h0008, 1, 0);
      check("t1_idx3", {28'd0, fp_idx}, 32'd3);
      step(16'h0000, 1, 0);
      check("t1_empty", {31'd0, fp_valid}, 32'd0);

      // All 16 pending drain in index order
      step(16'hFFFF, 1, 0);
      check("t2_idx0", {28'd0, fp_idx}, 32'd0);
      for (int i = 1; i < 16; i++) begin
         step(16'h0000, 1, 0);
         check("t2_seq", {28'd0, fp_idx}, i);
      end
      step(16'h0000, 1, 0);
      check("t2_done", {31'd0, fp_valid}, 32'd0);

      // Stall holds presentation, then 0 then 2
      step(16'h0005, 0, 0);
      for (int i = 0; i < 4; i++) step(16'h0000, 0, 0);
      check("t3_hold_idx",  {28'd0, fp_idx}, 32'd0);
      check("t3_hold_pend", {16'd0, fp_pend}, 32'h0005);
      step(16'h0000, 1, 0);
      check("t3_idx2", {28'd0, fp_idx}, 32'd2);
      step(16'h0000, 1, 0);

      // Request on the presented index while stalled coalesces
      step(16'h0004, 0, 0);
      step(16'h0004, 0, 0);
      check("t4_merged", {31'd0, fp_mrg}, 32'd1);
      step(16'h0000, 0, 0);
      check("t4_merged_pulse", {31'd0, fp_mrg}, 32'd0);
      step(16'h0000, 1, 0);
      check("t4_no_dup", {31'd0, fp_valid}, 32'd0);

      // Round-robin wrap after accepting 14
      step(16'h4000, 0, 0);
      step(16'h4001, 1, 0);
      check("t5_rr_idx0", {28'd0, rr_idx}, 32'd0);
      step(16'h0000, 1, 0);
      check("t5_rr_idx14", {28'd0, rr_idx}, 32'd14);
      step(16'h0000, 1, 0);

      // Synchronous clear discards a stalled presentation and ignores in
      step(16'h00F0, 0, 0);
      step(16'h0001, 0, 1);
      check("t6_clr_valid", {31'd0, fp_valid}, 32'd0);
      check("t6_clr_pend",  {16'd0, rr_pend},  32'd0);

      // Asynchronous reset mid-cycle
      step(16'h00F0, 0, 0);
      in = '0; out_ready = 1'b0;
      #3 rst_n = 1'b0;
      mreset();
      #1;
      check("t6_async_valid", {31'd0, fp_valid}, 32'd0);
      check("t6_async_pend",  {16'd0, fp_pend},  32'd0);
      check("t6_async_rr",    {31'd0, rr_valid}, 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;

      // Random traffic
      for (int n = 0; n < 500; n++) begin
         logic [15:0] vin;
         vin = 16'($urandom) & 16'($urandom) & 16'($urandom);
         if ($urandom_range(0, 2) == 0) vin = '0;
         step(vin, $urandom_range(0, 3) != 0, $urandom_range(0, 59) == 0);
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
